// File: rtl/streaming_pkg.sv
// Shared constants and state encoding for the serial streaming link.
// Used by both the receiver and the transmitter so framing stays in sync.
package streaming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEP  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic SEP_BIT   = 1'b0;

    localparam int DEF_DATA_W = 8;
    localparam int FRAME_LEN  = DEF_DATA_W + 2;

    function automatic int frame_len(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO; a push into a full FIFO without a pop is dropped
// and reported as a one-cycle overflow pulse.
module stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);
    assign w_drop  = i_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_drop;
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    assign o_data     = w_empty ? '0 : r_mem[r_rd];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/streaming_in.sv
// One-wire streaming receiver: start/separator framing, MSB-first payload,
// recovered words buffered in a FIFO with a valid/ready output.
module streaming_in
    import streaming_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dIn,
    output logic [DATA_W-1:0] dOut,
    output logic              outValid,
    input  logic              outReady,
    output logic              frameErr,
    output logic              overrun
);

    localparam int CW = $clog2(DATA_W);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_frame_err;

    logic              w_push;
    logic [DATA_W-1:0] w_word;
    logic              w_full;
    logic              w_empty;

    // The word is pushed on the same edge that samples its last bit.
    assign w_push = (r_state == DATA) && (r_cnt == '0);
    assign w_word = {r_shift[DATA_W-2:0], dIn};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dIn == START_BIT) begin
                        r_state <= SEP;
                    end
                end
                SEP: begin
                    if (dIn == SEP_BIT) begin
                        r_state <= DATA;
                        r_cnt   <= CW'(DATA_W - 1);
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                DATA: begin
                    r_shift <= w_word;
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    stream_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     (w_word),
        .i_pop      (outReady),
        .o_data     (dOut),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (overrun)
    );

    assign outValid = ~w_empty;
    assign frameErr = r_frame_err;

endmodule

// File: tb/tb_streaming_in.sv
// Scenario-driven bench for streaming_in with a queue scoreboard of
// expected output words.
module tb_streaming_in;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          dIn;
    logic [DW-1:0] dOut;
    logic          outValid;
    logic          outReady;
    logic          frameErr;
    logic          overrun;

    int checks;
    int errors;
    int cyc;
    int n_err;
    int n_ovf;

    logic [DW-1:0] sb[$];
    int            pop_cyc[$];

    streaming_in #(
        .DATA_W     (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dIn      (dIn),
        .dOut     (dOut),
        .outValid (outValid),
        .outReady (outReady),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // One clock step: scoreboard the pre-edge handshake, then return at negedge.
    task automatic tick();
        logic [DW-1:0] exp_w;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (outValid && outReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h required none", dOut);
                end else begin
                    exp_w = sb.pop_front();
                    if (dOut !== exp_w) begin
                        errors++;
                        $display("FAIL word got %h required %h", dOut, exp_w);
                    end
                    pop_cyc.push_back(cyc);
                end
            end
            if (frameErr) n_err++;
            if (overrun) n_ovf++;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit expect_out,
                              input bit rdy_last);
        logic [DW+1:0] bits;
        bits = {1'b1, 1'b0, w};
        if (expect_out) sb.push_back(w);
        for (int i = DW + 1; i >= 0; i--) begin
            dIn = bits[i];
            if (i == 0 && rdy_last) outReady = 1'b1;
            tick();
        end
        dIn = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !outValid) break;
            tick();
        end
        checks++;
        if (sb.size() != 0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain left %0d valid %b required 0 0",
                     name, sb.size(), outValid);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dIn = 1'b0;
        outReady = 1'b1;
        tick();
        tick();
        checks++;
        if (outValid !== 1'b0 || dOut !== '0 || frameErr !== 1'b0 ||
            overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b %h %b %b required 0 00 0 0",
                     outValid, dOut, frameErr, overrun);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int e0;
        int o0;
        e0 = n_err;
        o0 = n_ovf;
        outReady = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        checks++;
        if (outValid !== 1'b1 || dOut !== 8'hA5) begin
            errors++;
            $display("FAIL single_valid got %b %h required 1 a5", outValid, dOut);
        end
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_beat got %b required 0", outValid);
        end
        wait_drain("single");
        checks++;
        if (n_err != e0 || n_ovf != o0) begin
            errors++;
            $display("FAIL single_flags got %0d %0d required 0 0",
                     n_err - e0, n_ovf - o0);
        end
    endtask

    task automatic test_back_to_back();
        pop_cyc.delete();
        outReady = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_drain("b2b");
        checks++;
        if (pop_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_beats got %0d required 2", pop_cyc.size());
        end else if (pop_cyc[1] - pop_cyc[0] != 10) begin
            errors++;
            $display("FAIL b2b_spacing got %0d required 10",
                     pop_cyc[1] - pop_cyc[0]);
        end
    endtask

    task automatic test_sep_error();
        int e0;
        e0 = n_err;
        outReady = 1'b1;
        dIn = 1'b1;
        tick();
        dIn = 1'b1;
        tick();
        checks++;
        if (frameErr !== 1'b1) begin
            errors++;
            $display("FAIL sep_err_pulse got %b required 1", frameErr);
        end
        dIn = 1'b0;
        tick();
        checks++;
        if (frameErr !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL sep_err_after got %b %b required 0 0",
                     frameErr, outValid);
        end
        tick();
        tick();
        send_frame(8'h81, 1'b1, 1'b0);
        checks++;
        if (outValid !== 1'b1 || dOut !== 8'h81) begin
            errors++;
            $display("FAIL sep_recover got %b %h required 1 81", outValid, dOut);
        end
        wait_drain("sep");
        checks++;
        if (n_err - e0 != 1) begin
            errors++;
            $display("FAIL sep_err_count got %0d required 1", n_err - e0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = n_ovf;
        outReady = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || outValid !== 1'b1 || dOut !== 8'h01) begin
            errors++;
            $display("FAIL ovr_pulse got %b %b %h required 1 1 01",
                     overrun, outValid, dOut);
        end
        tick();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_one_cycle got %b required 0", overrun);
        end
        outReady = 1'b1;
        wait_drain("ovr");
        checks++;
        if (n_ovf - o0 != 1) begin
            errors++;
            $display("FAIL ovr_count got %0d required 1", n_ovf - o0);
        end
    endtask

    task automatic test_full_pop();
        int o0;
        o0 = n_ovf;
        outReady = 1'b0;
        send_frame(8'h06, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h04, 1'b1, 1'b1);
        checks++;
        if (overrun !== 1'b0 || outValid !== 1'b1 || dOut !== 8'h07) begin
            errors++;
            $display("FAIL full_pop got %b %b %h required 0 1 07",
                     overrun, outValid, dOut);
        end
        wait_drain("fullpop");
        checks++;
        if (n_ovf != o0) begin
            errors++;
            $display("FAIL full_pop_ovr got %0d required 0", n_ovf - o0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [5:0] part;
        part = 6'b10_1101;
        outReady = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            dIn = part[i];
            tick();
        end
        rst = 1'b1;
        dIn = 1'b0;
        tick();
        checks++;
        if (outValid !== 1'b0 || dOut !== '0 || frameErr !== 1'b0 ||
            overrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b %h %b %b required 0 00 0 0",
                     outValid, dOut, frameErr, overrun);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (outValid !== 1'b0 || frameErr !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet got %b %b required 0 0",
                         outValid, frameErr);
            end
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        checks++;
        if (outValid !== 1'b1 || dOut !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_word got %b %h required 1 5a", outValid, dOut);
        end
        wait_drain("midrst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        n_err = 0;
        n_ovf = 0;
        rst = 1'b1;
        dIn = 1'b0;
        outReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_sep_error();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
